// File: rtl/pqsdn_cam_pkg.sv
// Shared types and constants for the CAM table controller: FSM state encoding,
// the reserved invalid key pattern and the update opcodes.
package pqsdn_cam_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StUpdWr,
        StUpdWait,
        StLkpA,
        StLkpB,
        StResp
    } cam_state_e;

    // Widest key supported; users slice the low DATA_W bits.
    localparam int unsigned MAX_DATA_W = 1024;
    localparam logic [MAX_DATA_W-1:0] INVALID_KEY = '1;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

endpackage

// File: rtl/pqsdn_cam_ctrl_if.sv
// Request/result handshakes plus the CAM write/search port of the CAM controller.
interface pqsdn_cam_ctrl_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned EN_W   = DATA_W / 8
);
    logic              lkp_valid_i;
    logic              lkp_ready_o;
    logic [DATA_W-1:0] lkp_key_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic              res_hit_o;
    logic [ADDR_W-1:0] res_addr_o;
    logic              upd_valid_i;
    logic              upd_ready_o;
    logic              upd_op_i;
    logic [DATA_W-1:0] upd_key_i;
    logic [ADDR_W-1:0] upd_addr_i;
    logic              upd_done_o;
    logic              upd_err_o;
    logic [ADDR_W-1:0] upd_addr_o;
    logic              cam_en_a_o;
    logic [EN_W-1:0]   cam_wren_a_o;
    logic [ADDR_W-1:0] cam_wraddr_a_o;
    logic [DATA_W-1:0] cam_wrdata_a_o;
    logic              cam_rden_b_o;
    logic [DATA_W-1:0] cam_rddata_b_o;
    logic [ADDR_W-1:0] cam_rdaddr_b_i;

    modport master (
        output lkp_valid_i, lkp_key_i, res_ready_i, upd_valid_i, upd_op_i, upd_key_i,
               upd_addr_i, cam_rdaddr_b_i,
        input  lkp_ready_o, res_valid_o, res_hit_o, res_addr_o, upd_ready_o, upd_done_o,
               upd_err_o, upd_addr_o, cam_en_a_o, cam_wren_a_o, cam_wraddr_a_o,
               cam_wrdata_a_o, cam_rden_b_o, cam_rddata_b_o
    );

    modport slave (
        input  lkp_valid_i, lkp_key_i, res_ready_i, upd_valid_i, upd_op_i, upd_key_i,
               upd_addr_i, cam_rdaddr_b_i,
        output lkp_ready_o, res_valid_o, res_hit_o, res_addr_o, upd_ready_o, upd_done_o,
               upd_err_o, upd_addr_o, cam_en_a_o, cam_wren_a_o, cam_wraddr_a_o,
               cam_wrdata_a_o, cam_rden_b_o, cam_rddata_b_o
    );
endinterface

// File: rtl/pqsdn_cam_free_enc.sv
// Lowest-free-entry priority encoder over the valid bitmap; entry 0 is never
// allocatable, so the bitmap passed in starts at bit 1.
module pqsdn_cam_free_enc #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic [2**ADDR_W-1:1] valid_i,
    output logic [ADDR_W-1:0]    free_idx_o,
    output logic                 full_o
);
    localparam int Depth = 2 ** ADDR_W;

    always_comb begin
        free_idx_o = '0;
        for (int i = Depth - 1; i >= 1; i--) begin
            if (!valid_i[i]) free_idx_o = ADDR_W'(i);
        end
        full_o = &valid_i;
    end

endmodule

// File: rtl/pqsdn_cam_ctrl.sv
// CAM table controller: initialises the CAM, allocates/frees entries and runs
// two-phase searches (park on a free entry, then search the key) against the CAM.
module pqsdn_cam_ctrl
    import pqsdn_cam_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned EN_W   = DATA_W / 8
) (
    input logic             clk,
    input logic             rst_n,
    pqsdn_cam_ctrl_if.slave bus
);
    localparam int unsigned       Depth      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   InitLast   = (ADDR_W + 1)'(Depth);
    localparam logic [DATA_W-1:0] InvalidKey = INVALID_KEY[DATA_W-1:0];

    cam_state_e        state_q;
    logic [Depth-1:1]  valid_hi_q;
    logic [Depth-1:0]  valid_all;
    logic [ADDR_W:0]   init_cnt_q;
    logic [DATA_W-1:0] key_q;

    logic              lkp_ready_q, upd_ready_q;
    logic              res_valid_q, res_hit_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic              upd_done_q, upd_err_q;
    logic [ADDR_W-1:0] upd_addr_q;
    logic              cam_en_q, cam_rden_q;
    logic [ADDR_W-1:0] cam_wraddr_q;
    logic [DATA_W-1:0] cam_wrdata_q, cam_rddata_q;

    logic [ADDR_W-1:0] free_idx;
    logic              table_full;
    logic              lkp_hit;
    logic              del_ok;

    assign valid_all = {valid_hi_q, 1'b0};

    pqsdn_cam_free_enc #(
        .ADDR_W(ADDR_W)
    ) u_free_enc (
        .valid_i   (valid_hi_q),
        .free_idx_o(free_idx),
        .full_o    (table_full)
    );

    // A parked or stale match address always lands on an entry whose valid bit is clear.
    assign lkp_hit = valid_all[bus.cam_rdaddr_b_i] && (key_q != InvalidKey);
    assign del_ok  = (bus.upd_addr_i != '0) && valid_all[bus.upd_addr_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            valid_hi_q   <= '0;
            init_cnt_q   <= '0;
            key_q        <= '0;
            lkp_ready_q  <= 1'b0;
            upd_ready_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_hit_q    <= 1'b0;
            res_addr_q   <= '0;
            upd_done_q   <= 1'b0;
            upd_err_q    <= 1'b0;
            upd_addr_q   <= '0;
            cam_en_q     <= 1'b0;
            cam_wraddr_q <= '0;
            cam_wrdata_q <= '0;
            cam_rden_q   <= 1'b0;
            cam_rddata_q <= '0;
        end else begin
            cam_en_q   <= 1'b0;
            upd_done_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (init_cnt_q < InitLast) begin
                        cam_en_q     <= 1'b1;
                        cam_wraddr_q <= init_cnt_q[ADDR_W-1:0];
                        cam_wrdata_q <= InvalidKey;
                        init_cnt_q   <= init_cnt_q + 1'b1;
                    end else if (init_cnt_q == InitLast) begin
                        // Idle cycle so the last write commits before searches start.
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end else begin
                        state_q     <= StIdle;
                        lkp_ready_q <= 1'b1;
                        upd_ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (bus.upd_valid_i) begin
                        lkp_ready_q <= 1'b0;
                        upd_ready_q <= 1'b0;
                        state_q     <= StUpdWr;
                        if (bus.upd_op_i == OP_INSERT) begin
                            upd_err_q  <= table_full;
                            upd_addr_q <= table_full ? '0 : free_idx;
                            if (!table_full) begin
                                cam_en_q               <= 1'b1;
                                cam_wraddr_q           <= free_idx;
                                cam_wrdata_q           <= bus.upd_key_i;
                                valid_hi_q[free_idx]   <= 1'b1;
                            end
                        end else begin
                            upd_err_q  <= !del_ok;
                            upd_addr_q <= del_ok ? bus.upd_addr_i : '0;
                            if (del_ok) begin
                                cam_en_q                   <= 1'b1;
                                cam_wraddr_q               <= bus.upd_addr_i;
                                cam_wrdata_q               <= InvalidKey;
                                valid_hi_q[bus.upd_addr_i] <= 1'b0;
                            end
                        end
                    end else if (bus.lkp_valid_i) begin
                        lkp_ready_q  <= 1'b0;
                        upd_ready_q  <= 1'b0;
                        key_q        <= bus.lkp_key_i;
                        cam_rden_q   <= 1'b1;
                        cam_rddata_q <= InvalidKey;
                        state_q      <= StLkpA;
                    end
                end
                StUpdWr: begin
                    upd_done_q <= 1'b1;
                    state_q    <= StUpdWait;
                end
                StUpdWait: begin
                    lkp_ready_q <= 1'b1;
                    upd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                StLkpA: begin
                    cam_rddata_q <= key_q;
                    state_q      <= StLkpB;
                end
                StLkpB: begin
                    cam_rden_q   <= 1'b0;
                    cam_rddata_q <= '0;
                    res_valid_q  <= 1'b1;
                    res_hit_q    <= lkp_hit;
                    res_addr_q   <= lkp_hit ? bus.cam_rdaddr_b_i : '0;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (bus.res_ready_i) begin
                        res_valid_q <= 1'b0;
                        lkp_ready_q <= 1'b1;
                        upd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign bus.lkp_ready_o    = lkp_ready_q;
    assign bus.upd_ready_o    = upd_ready_q;
    assign bus.res_valid_o    = res_valid_q;
    assign bus.res_hit_o      = res_hit_q;
    assign bus.res_addr_o     = res_addr_q;
    assign bus.upd_done_o     = upd_done_q;
    assign bus.upd_err_o      = upd_err_q;
    assign bus.upd_addr_o     = upd_addr_q;
    assign bus.cam_en_a_o     = cam_en_q;
    assign bus.cam_wren_a_o   = {EN_W{1'b1}};
    assign bus.cam_wraddr_a_o = cam_wraddr_q;
    assign bus.cam_wrdata_a_o = cam_wrdata_q;
    assign bus.cam_rden_b_o   = cam_rden_q;
    assign bus.cam_rddata_b_o = cam_rddata_q;

endmodule
